// File: rtl/xil_arb_pkg.sv
// Shared types and defaults for the Xilinx-link source arbiter.
// Combinational helper only; no state lives here.
package xil_arb_pkg;

    localparam int XIL_ARB_N_SRC   = 4;
    localparam int XIL_ARB_DW      = 32;
    localparam int XIL_ARB_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

    // (a + b) mod n for a, b < n; avoids a divider for non power-of-two n.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/xil_src_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after i_ptr, wrapping N-1 -> 0.
// Purely combinational, zero latency; o_gnt_vld low when no requester.
module xil_src_arbiter_rr_pick
    import xil_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_vld
);

    int unsigned w_idx;

    // Scan from the farthest slot back to the pointer so the nearest requester wins last.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = wrap_add(32'(i_ptr), unsigned'(k), unsigned'(N));
            if (i_req[w_idx]) begin
                o_gnt_idx = IW'(w_idx);
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xil_src_arbiter.sv
// Round-robin share of the link word channel among N_SRC producers; grant 1 cycle after decision,
// data_rdy 1 cycle after src_data_rdy; link back-pressure via rdy_for_data level, one word per high period.
module xil_src_arbiter
    import xil_arb_pkg::*;
#(
    parameter int N_SRC   = XIL_ARB_N_SRC,
    parameter int DW      = XIL_ARB_DW,
    parameter int TIMEOUT = XIL_ARB_TIMEOUT,
    localparam int IW     = $clog2(N_SRC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy_for_data,
    output logic                data_rdy,
    output logic [DW-1:0]       data_in,
    input  logic [N_SRC-1:0]    src_req,
    output logic [N_SRC-1:0]    src_rdy_for_data,
    input  logic [N_SRC-1:0]    src_data_rdy,
    input  logic [N_SRC*DW-1:0] src_data,
    output logic                busy,
    output logic [IW-1:0]       grant_id,
    output logic                err_timeout,
    output logic [IW-1:0]       err_id
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_grant_id;
    logic [IW-1:0]     r_err_id;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_data;
    logic              r_data_rdy;
    logic              r_err_timeout;
    logic              r_busy;
    logic [N_SRC-1:0]  r_src_rdy;

    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_vld;
    logic [IW-1:0]     w_ptr_nxt;
    logic              w_g_data_rdy;
    logic [DW-1:0]     w_g_data;
    logic              w_cnt_done;

    xil_src_arbiter_rr_pick #(
        .N  (N_SRC),
        .IW (IW)
    ) u_rr_pick (
        .i_req     (src_req),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_vld (w_pick_vld)
    );

    assign w_ptr_nxt    = IW'(wrap_add(32'(r_grant_id), 32'd1, unsigned'(N_SRC)));
    assign w_g_data_rdy = src_data_rdy[r_grant_id];
    assign w_g_data     = src_data[r_grant_id*DW +: DW];
    assign w_cnt_done   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_id    <= '0;
            r_err_id      <= '0;
            r_cnt         <= '0;
            r_data        <= '0;
            r_data_rdy    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_src_rdy     <= '0;
        end else begin
            r_data_rdy    <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (rdy_for_data && w_pick_vld) begin
                        r_grant_id <= w_pick_idx;
                        r_src_rdy  <= N_SRC'(1) << w_pick_idx;
                        r_busy     <= 1'b1;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Capture beats a same-cycle abort or timeout.
                    if (w_g_data_rdy) begin
                        r_data     <= w_g_data;
                        r_data_rdy <= 1'b1;
                        r_src_rdy  <= '0;
                        r_ptr      <= w_ptr_nxt;
                        r_cnt      <= '0;
                        r_state    <= ST_HOLD;
                    end else if (!rdy_for_data) begin
                        r_src_rdy <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_cnt_done) begin
                        r_err_timeout <= 1'b1;
                        r_err_id      <= r_grant_id;
                        r_src_rdy     <= '0;
                        r_ptr         <= w_ptr_nxt;
                        r_cnt         <= '0;
                        r_state       <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    r_cnt <= '0;
                    if (!rdy_for_data) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_src_rdy <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_rdy         = r_data_rdy;
    assign data_in          = r_data;
    assign src_rdy_for_data = r_src_rdy;
    assign busy             = r_busy;
    assign grant_id         = r_grant_id;
    assign err_timeout      = r_err_timeout;
    assign err_id           = r_err_id;

    // Grant is one-hot and present exactly while in GRANT; output pulses only land in HOLD.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_src_rdy));
    a_grant_state: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_src_rdy != '0) == (r_state == ST_GRANT)));
    a_pulse_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_data_rdy || r_err_timeout) |-> (r_state == ST_HOLD)));

endmodule

// File: tb/tb_xil_src_arbiter.sv
// Randomized bench for xil_src_arbiter against a transaction-level round-robin model.
module tb_xil_src_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            rst_n;
    logic            rdy_for_data;
    logic            data_rdy;
    logic [DW-1:0]   data_in;
    logic [N-1:0]    src_req;
    logic [N-1:0]    src_rdy_for_data;
    logic [N-1:0]    src_data_rdy;
    logic [N*DW-1:0] src_data;
    logic            busy;
    logic [1:0]      grant_id;
    logic            err_timeout;
    logic [1:0]      err_id;

    int n_chk;
    int n_err;

    int          m_ptr;
    logic [31:0] m_data;
    logic [31:0] w [N];

    xil_src_arbiter #(
        .N_SRC   (N),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rdy_for_data     (rdy_for_data),
        .data_rdy         (data_rdy),
        .data_in          (data_in),
        .src_req          (src_req),
        .src_rdy_for_data (src_rdy_for_data),
        .src_data_rdy     (src_data_rdy),
        .src_data         (src_data),
        .busy             (busy),
        .grant_id         (grant_id),
        .err_timeout      (err_timeout),
        .err_id           (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first requester scanning upward from the pointer, wrapping at N.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] stray(input int g);
        logic [N-1:0] r;
        r = N'($urandom);
        r[g] = 1'b0;
        return r;
    endfunction

    task automatic load_words();
        for (int i = 0; i < N; i++) begin
            w[i] = $urandom;
            src_data[i*DW +: DW] = w[i];
        end
    endtask

    // mode 0: respond after d cycles; 1: link drops after d cycles; 2: never respond;
    // 3: link drops in the same cycle the source responds.
    task automatic round(input logic [N-1:0] req, input int mode, input int d);
        int g;
        int n;
        rdy_for_data = 1'b0;
        src_data_rdy = '0;
        src_req      = req;
        n = 0;
        step();
        while (busy && n < 4) begin
            step();
            n++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_no_grant", src_rdy_for_data, 0);
        g = pick(req, m_ptr);
        rdy_for_data = 1'b1;
        step();
        if (g < 0) begin
            chk("no_req_grant", src_rdy_for_data, 0);
            chk("no_req_busy", busy, 0);
            return;
        end
        chk("grant", src_rdy_for_data, 64'd1 << g);
        chk("grant_id", grant_id, g);
        chk("grant_busy", busy, 1);
        for (int i = 0; i < d; i++) begin
            src_req      = N'($urandom);
            src_data_rdy = stray(g);
            step();
            chk("grant_held", src_rdy_for_data, 64'd1 << g);
            chk("wait_no_data", data_rdy, 0);
        end
        case (mode)
            0, 3: begin
                if (mode == 3) rdy_for_data = 1'b0;
                src_data_rdy = stray(g) | (N'(1) << g);
                step();
                m_data = w[g];
                m_ptr  = (g + 1) % N;
                chk("cap_data_rdy", data_rdy, 1);
                chk("cap_data_in", data_in, m_data);
                chk("cap_grant_clr", src_rdy_for_data, 0);
                chk("cap_no_err", err_timeout, 0);
                src_data_rdy = N'($urandom);
                step();
                chk("pulse_one_cycle", data_rdy, 0);
                chk("data_held", data_in, m_data);
                chk("hold_no_regrant", src_rdy_for_data, 0);
                chk("hold_busy", busy, (mode == 0) ? 1 : 0);
            end
            1: begin
                rdy_for_data = 1'b0;
                src_data_rdy = stray(g);
                step();
                chk("abort_grant_clr", src_rdy_for_data, 0);
                chk("abort_idle", busy, 0);
                chk("abort_no_data", data_rdy, 0);
                chk("abort_no_err", err_timeout, 0);
                chk("abort_data_held", data_in, m_data);
            end
            default: begin
                n = d;
                while (src_rdy_for_data !== '0 && n < 20) begin
                    src_data_rdy = stray(g);
                    step();
                    n++;
                end
                m_ptr = (g + 1) % N;
                chk("to_grant_cycles", n, TO);
                chk("to_pulse", err_timeout, 1);
                chk("to_err_id", err_id, g);
                chk("to_no_data", data_rdy, 0);
                src_data_rdy = '0;
                step();
                chk("to_pulse_end", err_timeout, 0);
                chk("to_err_id_held", err_id, g);
                chk("to_data_held", data_in, m_data);
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode;
        int g;
        n_chk        = 0;
        n_err        = 0;
        m_ptr        = 0;
        m_data       = '0;
        rst_n        = 1'b0;
        rdy_for_data = 1'b0;
        src_req      = '0;
        src_data_rdy = '0;
        src_data     = '0;
        step();
        step();
        chk("rst_data_rdy", data_rdy, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_grant", src_rdy_for_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err", {err_timeout, err_id}, 0);
        rst_n = 1'b1;

        // Single source with a known word, then again after the link re-arms.
        load_words();
        w[0] = 32'h1234_5678;
        src_data[31:0] = w[0];
        round(4'b0001, 0, 1);
        round(4'b0001, 0, 0);

        // All requesting: grants rotate through every source.
        for (int i = 0; i < 5; i++) begin
            load_words();
            round(4'b1111, 0, $urandom_range(0, 3));
        end

        // Drive the pointer to 3, then check wrap and skip of idle sources.
        round(4'b0100, 0, 1);
        round(4'b0110, 0, 1);
        round(4'b0110, 0, 2);
        chk("wrap_ptr", m_ptr, 3);

        // Silent source times out; the next grant moves on.
        round(4'b0100, 2, 0);
        round(4'b1100, 0, 1);

        // Link drops mid-grant; the same source is re-granted next time.
        round(4'b0011, 1, 2);
        round(4'b0011, 0, 1);
        round(4'b0110, 3, 2);

        // Reset in the middle of a grant.
        load_words();
        round(4'b0010, 2, 0);
        rdy_for_data = 1'b0;
        step();
        step();
        src_req = 4'b1000;
        rdy_for_data = 1'b1;
        step();
        g = pick(4'b1000, m_ptr);
        chk("pre_rst_grant", src_rdy_for_data, 64'd1 << g);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_ptr  = 0;
        m_data = '0;
        chk("mid_rst_data_rdy", data_rdy, 0);
        chk("mid_rst_data_in", data_in, 0);
        chk("mid_rst_grant", src_rdy_for_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ids", {grant_id, err_id, err_timeout}, 0);
        round(4'b1111, 0, 0);

        for (int r = 0; r < 80; r++) begin
            load_words();
            mode = $urandom_range(0, 3);
            round(N'($urandom), mode, (mode == 2) ? $urandom_range(0, TO - 1) : $urandom_range(0, 6));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
